alu_rs_ooo: RTL and testbench
=============================

// Module: alu_rs_ooo
// PURPOSE
// - Parametrised ALU reservation station with a single shared, registered ALU issue port.
// - Buffers dispatched ALU/jump ops and wakes their operands from an N-lane CDB.
// - Issues the oldest ready op each cycle and drives one result broadcast toward CDB arbitration.
// - Sits between decode/dispatch and the CDB arbiter; replaces per-entry ALU instancing.
// PARAMETERS
// - RS_DEPTH   8   entries in the station (>=2)
// - NUM_CDB    4   CDB lanes snooped for wakeup
// - ROB_DEPTH  8   ROB entries; TAG_W = $clog2(ROB_DEPTH)
// PORTS
// - clk                 in   1                clock
// - rst                 in   1                synchronous, active-high reset
// - flush               in   1                squash all entries and the result register
// - alloc_valid_i       in   1                dispatch offers an op
// - alloc_ready_o       out  1                station can accept (count < RS_DEPTH)
// - alloc_op_i          in   3                alu_ops encoding
// - alloc_jmp_i         in   2                none/jal/jalr
// - alloc_pc_i          in   32               instruction PC
// - alloc_rob_idx_i     in   TAG_W            destination ROB tag
// - alloc_rsN_rdy_i     in   1                operand N (1,2) value already valid
// - alloc_rsN_tag_i     in   TAG_W            producer tag if not ready
// - alloc_rsN_val_i     in   32               operand value if ready
// - cdb_valid_i         in   NUM_CDB          per-lane valid
// - cdb_tag_i           in   NUM_CDB*TAG_W    per-lane tag, lane k at [k*TAG_W +: TAG_W]
// - cdb_value_i         in   NUM_CDB*32       per-lane value
// - res_valid_o         out  1                result register holds a result
// - res_ready_i         in   1                arbiter accepts the result this cycle
// - res_tag_o           out  TAG_W            ROB tag of result
// - res_value_o         out  32               rd value
// - res_target_pc_o     out  32               jump target (0 for non-jump)
// - count_o             out  $clog2(RS_DEPTH)+1   occupied entries
// BEHAVIOUR
// - Reset/flush (flush equivalent to rst): all entries invalid; res_valid_o=0; res_* = 0;
//   count_o=0. Takes effect next edge; dominates same-cycle alloc, wakeup and issue.
// - Alloc: handshake fires on alloc_valid_i & alloc_ready_o. Op is written to the
//   lowest-index free entry and marked younger than every valid entry (age matrix).
// - alloc_ready_o is combinational from count_o only. When full it stays 0 even if an
//   issue frees an entry in the same cycle (no pass-through).
// - Wakeup: each not-ready operand compares its tag against every lane with cdb_valid_i=1;
//   on a match it captures the value and sets ready at the next edge. Lowest lane wins on
//   duplicate tags.
// - Same-cycle bypass at alloc: a not-ready alloc operand matching a valid CDB lane in the
//   alloc cycle is stored ready with the CDB value.
// - Issue: candidate = valid & rs1 ready & rs2 ready (registered bits). Select the candidate
//   with no older candidate.
//   - Issue allowed when !res_valid_o or res_ready_i (drain and refill in one cycle).
//   - The issued entry is freed at the same edge.
// - Latency: CDB match in cycle c -> ready at c+1 -> res_valid_o=1 at c+2 (if selected).
//   An op allocated with both operands ready gives res_valid_o two cycles after alloc.
// - Result: alu = f(op, rs1, rs2), 32-bit wrap; shifts use rs2[4:0].
//   - none: value = alu, target = 0.
//   - jal:  value = pc+4, target = alu.
//   - jalr: value = pc+4, target = alu & 32'hFFFF_FFFE.
// - Output hold: res_* stay stable while res_valid_o & !res_ready_i.
// - count_o next = count + alloc_fire - issue_fire; simultaneous alloc+issue leaves it unchanged.
// CONFIGURATION
// - ALU_RS_SELF_WAKE_EN defined: the result register (res_valid_o, res_tag_o, res_value_o)
//   also acts as an extra wakeup lane in every cycle res_valid_o=1. Back-to-back dependents
//   then issue one cycle after the producer result appears, without waiting for the CDB.
// - ALU_RS_SELF_WAKE_EN undefined: wakeup comes from cdb_* only.
// TESTING
// - rst mid-stream with 5 entries and res_valid_o=1 -> next cycle count_o=0,
//   res_valid_o=0, alloc_ready_o=1.
// - Alloc add r1=3, r2=4 ready, tag 2 -> res_valid_o at +2, res_tag_o=2, res_value_o=7.
// - Alloc op rs1 tag 5 unready; CDB lane 3 {5, 32'h10} in the alloc cycle -> entry ready
//   via bypass, result at +2.
// - Alloc A then B both waiting on tag 1; CDB tag 1 wakes both -> A issues first, B next
//   cycle; count_o goes 2->1->0.
// - Fill to 8 entries -> alloc_ready_o=0; hold res_ready_i=0 -> no issue, res_* stable;
//   raise res_ready_i -> drain and issue in one cycle.
// - jalr pc=0x100, rs1=0x203, imm=0 -> res_value_o=0x104, res_target_pc_o=0x202;
//   with SELF_WAKE_EN, a dependent on that tag issues without a CDB beat.

Source files
------------

// File: rtl/alu_rs_ooo.sv
// ALU reservation station: age-ordered issue into one registered result port.
// Optional: define ALU_RS_SELF_WAKE_EN to use the result register as a wakeup lane.
module alu_rs_ooo #(
    parameter int RS_DEPTH  = 8,
    parameter int NUM_CDB   = 4,
    parameter int ROB_DEPTH = 8,
    localparam int TAG_W    = $clog2(ROB_DEPTH),
    localparam int CNT_W    = $clog2(RS_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_valid_i,
    output logic                    alloc_ready_o,
    input  logic [2:0]              alloc_op_i,
    input  logic [1:0]              alloc_jmp_i,
    input  logic [31:0]             alloc_pc_i,
    input  logic [TAG_W-1:0]        alloc_rob_idx_i,
    input  logic                    alloc_rs1_rdy_i,
    input  logic [TAG_W-1:0]        alloc_rs1_tag_i,
    input  logic [31:0]             alloc_rs1_val_i,
    input  logic                    alloc_rs2_rdy_i,
    input  logic [TAG_W-1:0]        alloc_rs2_tag_i,
    input  logic [31:0]             alloc_rs2_val_i,
    input  logic [NUM_CDB-1:0]      cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_i,
    input  logic [NUM_CDB*32-1:0]   cdb_value_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [TAG_W-1:0]        res_tag_o,
    output logic [31:0]             res_value_o,
    output logic [31:0]             res_target_pc_o,
    output logic [CNT_W-1:0]        count_o
);

    localparam int IDX_W = $clog2(RS_DEPTH);
`ifdef ALU_RS_SELF_WAKE_EN
    localparam int NL = NUM_CDB + 1;
`else
    localparam int NL = NUM_CDB;
`endif

    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA
    } alu_op_e;

    localparam logic [1:0] JMP_JAL  = 2'd1;
    localparam logic [1:0] JMP_JALR = 2'd2;

    logic [RS_DEPTH-1:0] vld_q, vld_d;
    logic [RS_DEPTH-1:0] r1rdy_q, r1rdy_d;
    logic [RS_DEPTH-1:0] r2rdy_q, r2rdy_d;
    logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] older_d [RS_DEPTH];
    logic [2:0]          op_q    [RS_DEPTH];
    logic [2:0]          op_d    [RS_DEPTH];
    logic [1:0]          jmp_q   [RS_DEPTH];
    logic [1:0]          jmp_d   [RS_DEPTH];
    logic [31:0]         pc_q    [RS_DEPTH];
    logic [31:0]         pc_d    [RS_DEPTH];
    logic [TAG_W-1:0]    rob_q   [RS_DEPTH];
    logic [TAG_W-1:0]    rob_d   [RS_DEPTH];
    logic [TAG_W-1:0]    r1tag_q [RS_DEPTH];
    logic [TAG_W-1:0]    r1tag_d [RS_DEPTH];
    logic [TAG_W-1:0]    r2tag_q [RS_DEPTH];
    logic [TAG_W-1:0]    r2tag_d [RS_DEPTH];
    logic [31:0]         r1val_q [RS_DEPTH];
    logic [31:0]         r1val_d [RS_DEPTH];
    logic [31:0]         r2val_q [RS_DEPTH];
    logic [31:0]         r2val_d [RS_DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic             res_valid_q, res_valid_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;
    logic [31:0]      res_value_q, res_value_d;
    logic [31:0]      res_target_q, res_target_d;

    logic             wk_vld [NL];
    logic [TAG_W-1:0] wk_tag [NL];
    logic [31:0]      wk_val [NL];

    logic             alloc_fire;
    logic [IDX_W-1:0] free_idx;
    logic             al1_rdy, al2_rdy;
    logic [31:0]      al1_val, al2_val;

    logic [RS_DEPTH-1:0] cand;
    logic             iss_any, iss_fire;
    logic [IDX_W-1:0] iss_idx;
    logic [31:0]      opa, opb, alu, link;

    assign alloc_ready_o   = count_q < CNT_W'(RS_DEPTH);
    assign alloc_fire      = alloc_valid_i & alloc_ready_o;
    assign count_o         = count_q;
    assign res_valid_o     = res_valid_q;
    assign res_tag_o       = res_tag_q;
    assign res_value_o     = res_value_q;
    assign res_target_pc_o = res_target_q;

    always_comb begin
        for (int k = 0; k < NUM_CDB; k++) begin
            wk_vld[k] = cdb_valid_i[k];
            wk_tag[k] = cdb_tag_i[k*TAG_W +: TAG_W];
            wk_val[k] = cdb_value_i[k*32 +: 32];
        end
`ifdef ALU_RS_SELF_WAKE_EN
        // Result register sits behind every CDB lane in priority.
        wk_vld[NUM_CDB] = res_valid_q;
        wk_tag[NUM_CDB] = res_tag_q;
        wk_val[NUM_CDB] = res_value_q;
`endif
    end

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) free_idx = IDX_W'(i);
        end
    end

    // Scanning lanes high to low lets the lowest matching lane win.
    always_comb begin
        al1_rdy = alloc_rs1_rdy_i;
        al1_val = alloc_rs1_val_i;
        al2_rdy = alloc_rs2_rdy_i;
        al2_val = alloc_rs2_val_i;
        for (int k = NL - 1; k >= 0; k--) begin
            if (!alloc_rs1_rdy_i && wk_vld[k] && wk_tag[k] == alloc_rs1_tag_i) begin
                al1_rdy = 1'b1;
                al1_val = wk_val[k];
            end
            if (!alloc_rs2_rdy_i && wk_vld[k] && wk_tag[k] == alloc_rs2_tag_i) begin
                al2_rdy = 1'b1;
                al2_val = wk_val[k];
            end
        end
    end

    always_comb begin
        cand    = vld_q & r1rdy_q & r2rdy_q;
        iss_any = |cand;
        iss_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cand[i] && (cand & older_q[i]) == '0) iss_idx = IDX_W'(i);
        end
        iss_fire = iss_any & (~res_valid_q | res_ready_i);
    end

    always_comb begin
        opa  = r1val_q[iss_idx];
        opb  = r2val_q[iss_idx];
        link = pc_q[iss_idx] + 32'd4;
        unique case (alu_op_e'(op_q[iss_idx]))
            OP_ADD: alu = opa + opb;
            OP_SUB: alu = opa - opb;
            OP_AND: alu = opa & opb;
            OP_OR:  alu = opa | opb;
            OP_XOR: alu = opa ^ opb;
            OP_SLL: alu = opa << opb[4:0];
            OP_SRL: alu = opa >> opb[4:0];
            OP_SRA: alu = $unsigned($signed(opa) >>> opb[4:0]);
        endcase
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_tag_d    = res_tag_q;
        res_value_d  = res_value_q;
        res_target_d = res_target_q;
        if (iss_fire) begin
            res_valid_d = 1'b1;
            res_tag_d   = rob_q[iss_idx];
            case (jmp_q[iss_idx])
                JMP_JAL: begin
                    res_value_d  = link;
                    res_target_d = alu;
                end
                JMP_JALR: begin
                    res_value_d  = link;
                    res_target_d = alu & 32'hFFFF_FFFE;
                end
                default: begin
                    res_value_d  = alu;
                    res_target_d = 32'd0;
                end
            endcase
        end else if (res_ready_i) begin
            res_valid_d = 1'b0;
        end
    end

    always_comb begin
        vld_d   = vld_q;
        r1rdy_d = r1rdy_q;
        r2rdy_d = r2rdy_q;
        older_d = older_q;
        op_d    = op_q;
        jmp_d   = jmp_q;
        pc_d    = pc_q;
        rob_d   = rob_q;
        r1tag_d = r1tag_q;
        r2tag_d = r2tag_q;
        r1val_d = r1val_q;
        r2val_d = r2val_q;
        count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(iss_fire);
        for (int i = 0; i < RS_DEPTH; i++) begin
            for (int k = NL - 1; k >= 0; k--) begin
                if (vld_q[i] && !r1rdy_q[i] && wk_vld[k] && wk_tag[k] == r1tag_q[i]) begin
                    r1rdy_d[i] = 1'b1;
                    r1val_d[i] = wk_val[k];
                end
                if (vld_q[i] && !r2rdy_q[i] && wk_vld[k] && wk_tag[k] == r2tag_q[i]) begin
                    r2rdy_d[i] = 1'b1;
                    r2val_d[i] = wk_val[k];
                end
            end
        end
        if (iss_fire) vld_d[iss_idx] = 1'b0;
        if (alloc_fire) begin
            vld_d[free_idx]   = 1'b1;
            op_d[free_idx]    = alloc_op_i;
            jmp_d[free_idx]   = alloc_jmp_i;
            pc_d[free_idx]    = alloc_pc_i;
            rob_d[free_idx]   = alloc_rob_idx_i;
            r1tag_d[free_idx] = alloc_rs1_tag_i;
            r2tag_d[free_idx] = alloc_rs2_tag_i;
            r1rdy_d[free_idx] = al1_rdy;
            r2rdy_d[free_idx] = al2_rdy;
            r1val_d[free_idx] = al1_val;
            r2val_d[free_idx] = al2_val;
            // New entry is younger than every live one; clear stale column bits.
            older_d[free_idx] = vld_q;
            for (int i = 0; i < RS_DEPTH; i++) older_d[i][free_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q        <= '0;
            r1rdy_q      <= '0;
            r2rdy_q      <= '0;
            count_q      <= '0;
            res_valid_q  <= 1'b0;
            res_tag_q    <= '0;
            res_value_q  <= '0;
            res_target_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
        end else begin
            vld_q        <= vld_d;
            r1rdy_q      <= r1rdy_d;
            r2rdy_q      <= r2rdy_d;
            count_q      <= count_d;
            res_valid_q  <= res_valid_d;
            res_tag_q    <= res_tag_d;
            res_value_q  <= res_value_d;
            res_target_q <= res_target_d;
            older_q      <= older_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q    <= op_d;
        jmp_q   <= jmp_d;
        pc_q    <= pc_d;
        rob_q   <= rob_d;
        r1tag_q <= r1tag_d;
        r2tag_q <= r2tag_d;
        r1val_q <= r1val_d;
        r2val_q <= r2val_d;
    end

endmodule

// File: tb/tb_alu_rs_ooo.sv
// Directed bench for alu_rs_ooo: wakeup, bypass, age order, full/hold, jumps.
module tb_alu_rs_ooo;

    logic         clk = 1'b0;
    logic         rst, flush;
    logic         alloc_valid, alloc_ready;
    logic [2:0]   a_op;
    logic [1:0]   a_jmp;
    logic [31:0]  a_pc;
    logic [2:0]   a_rob;
    logic         a_r1rdy, a_r2rdy;
    logic [2:0]   a_r1tag, a_r2tag;
    logic [31:0]  a_r1val, a_r2val;
    logic [3:0]   cdb_valid;
    logic [11:0]  cdb_tag;
    logic [127:0] cdb_value;
    logic         res_valid, res_ready;
    logic [2:0]   res_tag;
    logic [31:0]  res_value, res_target;
    logic [3:0]   count;

    int total = 0;
    int bad   = 0;

    alu_rs_ooo dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_op_i(a_op), .alloc_jmp_i(a_jmp), .alloc_pc_i(a_pc),
        .alloc_rob_idx_i(a_rob),
        .alloc_rs1_rdy_i(a_r1rdy), .alloc_rs1_tag_i(a_r1tag), .alloc_rs1_val_i(a_r1val),
        .alloc_rs2_rdy_i(a_r2rdy), .alloc_rs2_tag_i(a_r2tag), .alloc_rs2_val_i(a_r2val),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_value_i(cdb_value),
        .res_valid_o(res_valid), .res_ready_i(res_ready),
        .res_tag_o(res_tag), .res_value_o(res_value),
        .res_target_pc_o(res_target), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        cdb_valid   = '0;
    endtask

    task automatic alloc(input logic [2:0] op, input logic [1:0] jmp,
                         input logic [31:0] pc, input logic [2:0] rob,
                         input logic r1r, input logic [2:0] r1t, input logic [31:0] r1v,
                         input logic r2r, input logic [2:0] r2t, input logic [31:0] r2v);
        alloc_valid = 1'b1;
        a_op = op; a_jmp = jmp; a_pc = pc; a_rob = rob;
        a_r1rdy = r1r; a_r1tag = r1t; a_r1val = r1v;
        a_r2rdy = r2r; a_r2tag = r2t; a_r2val = r2v;
    endtask

    task automatic cdb(input int lane, input logic [2:0] t, input logic [31:0] v);
        cdb_valid[lane]         = 1'b1;
        cdb_tag[lane*3 +: 3]    = t;
        cdb_value[lane*32 +: 32] = v;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
        total++; if (res_value !== 32'd0) begin bad++; $display("FAIL reset_value got=%h exp=0", res_value); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        alloc(3'd0, 2'd0, 32'h40, 3'd2, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd4);
        step(); idle();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_early got=%b exp=0", res_valid); end
        total++; if (count !== 4'd1) begin bad++; $display("FAIL add_count1 got=%0d exp=1", count); end
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", res_valid); end
        total++; if (res_tag !== 3'd2) begin bad++; $display("FAIL add_tag got=%0d exp=2", res_tag); end
        total++; if (res_value !== 32'd7) begin bad++; $display("FAIL add_value got=%h exp=7", res_value); end
        total++; if (res_target !== 32'd0) begin bad++; $display("FAIL add_target got=%h exp=0", res_target); end
        total++; if (count !== 4'd0) begin bad++; $display("FAIL add_count0 got=%0d exp=0", count); end
        step();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", res_valid); end
    endtask

    task automatic test_bypass();
        alloc(3'd0, 2'd0, 32'd0, 3'd3, 1'b0, 3'd5, 32'd0, 1'b1, 3'd0, 32'd1);
        cdb(3, 3'd5, 32'h10);
        step(); idle();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL byp_count got=%0d exp=1", count); end
        step();
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b exp=1", res_valid); end
        total++; if (res_value !== 32'h11) begin bad++; $display("FAIL byp_value got=%h exp=11", res_value); end
        total++; if (res_tag !== 3'd3) begin bad++; $display("FAIL byp_tag got=%0d exp=3", res_tag); end
        step();
    endtask

    task automatic test_dup_lanes();
        alloc(3'd0, 2'd0, 32'd0, 3'd4, 1'b1, 3'd0, 32'd0, 1'b0, 3'd3, 32'd0);
        step(); idle();
        cdb(1, 3'd3, 32'hAA);
        cdb(2, 3'd3, 32'hBB);
        step(); idle();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL dup_early got=%b exp=0", res_valid); end
        step();
        total++; if (res_value !== 32'hAA) begin bad++; $display("FAIL dup_value got=%h exp=aa", res_value); end
        total++; if (res_tag !== 3'd4) begin bad++; $display("FAIL dup_tag got=%0d exp=4", res_tag); end
        step();
    endtask

    task automatic test_wake_order();
        alloc(3'd0, 2'd0, 32'd0, 3'd3, 1'b0, 3'd1, 32'd0, 1'b1, 3'd0, 32'd1);
        step();
        alloc(3'd0, 2'd0, 32'd0, 3'd4, 1'b0, 3'd1, 32'd0, 1'b1, 3'd0, 32'd2);
        step(); idle();
        cdb(0, 3'd1, 32'd100);
        total++; if (count !== 4'd2) begin bad++; $display("FAIL wo_count2a got=%0d exp=2", count); end
        step(); idle();
        total++; if (count !== 4'd2) begin bad++; $display("FAIL wo_count2b got=%0d exp=2", count); end
        step();
        total++; if (count !== 4'd1) begin bad++; $display("FAIL wo_count1 got=%0d exp=1", count); end
        total++; if (res_tag !== 3'd3 || res_value !== 32'd101)
            begin bad++; $display("FAIL wo_first got=%0d/%0d exp=3/101", res_tag, res_value); end
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL wo_count0 got=%0d exp=0", count); end
        total++; if (res_tag !== 3'd4 || res_value !== 32'd102)
            begin bad++; $display("FAIL wo_second got=%0d/%0d exp=4/102", res_tag, res_value); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [31:0] va  [8] = '{32'd5, 32'd5, 32'hF0F0, 32'hF000, 32'hFF, 32'd1,
                                 32'h8000_0000, 32'h8000_0000};
        logic [31:0] vb  [8] = '{32'd7, 32'd7, 32'h0FF0, 32'h000F, 32'h0F, 32'd33,
                                 32'd4, 32'd4};
        logic [31:0] ex  [8] = '{32'd12, 32'hFFFF_FFFE, 32'h00F0, 32'hF00F, 32'hF0,
                                 32'd2, 32'h0800_0000, 32'hF800_0000};
        for (int n = 0; n <= 8; n++) begin
            if (n < 8) alloc(ops[n], 2'd0, 32'd0, 3'(n), 1'b1, 3'd0, va[n], 1'b1, 3'd0, vb[n]);
            else idle();
            step();
            if (n >= 1) begin
                total++;
                if (res_valid !== 1'b1 || res_tag !== 3'(n - 1) || res_value !== ex[n-1])
                    begin bad++; $display("FAIL b2b_op%0d got=%b/%0d/%h exp=1/%0d/%h",
                        n - 1, res_valid, res_tag, res_value, n - 1, ex[n-1]); end
            end
        end
        step();
        total++; if (res_valid !== 1'b0 || count !== 4'd0)
            begin bad++; $display("FAIL b2b_end got=%b/%0d exp=0/0", res_valid, count); end
    endtask

    task automatic test_full();
        res_ready = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            alloc(3'd0, 2'd0, 32'd0, 3'(k), 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'd10);
            step();
        end
        alloc(3'd0, 2'd0, 32'd0, 3'd1, 1'b1, 3'd0, 32'd99, 1'b1, 3'd0, 32'd99);
        total++; if (count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", count); end
        total++; if (alloc_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", alloc_ready); end
        total++; if (res_valid !== 1'b1 || res_tag !== 3'd0 || res_value !== 32'd10)
            begin bad++; $display("FAIL full_res got=%b/%0d/%0d exp=1/0/10", res_valid, res_tag, res_value); end
        for (int h = 0; h < 2; h++) begin
            step();
            total++; if (count !== 4'd8 || res_valid !== 1'b1 || res_tag !== 3'd0 || res_value !== 32'd10)
                begin bad++; $display("FAIL full_hold%0d got=%0d/%b/%0d/%0d exp=8/1/0/10",
                    h, count, res_valid, res_tag, res_value); end
        end
        res_ready = 1'b1;
        step(); idle();
        total++; if (count !== 4'd7) begin bad++; $display("FAIL full_nopass got=%0d exp=7", count); end
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL full_ready1 got=%b exp=1", alloc_ready); end
        total++; if (res_tag !== 3'd1 || res_value !== 32'd11)
            begin bad++; $display("FAIL full_refill got=%0d/%0d exp=1/11", res_tag, res_value); end
        for (int i = 2; i <= 8; i++) begin
            step();
            total++;
            if (count !== 4'(8 - i) || res_tag !== 3'(i) || res_value !== 32'(i + 10))
                begin bad++; $display("FAIL full_drain%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                    i, count, res_tag, res_value, 8 - i, i % 8, i + 10); end
        end
        step();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%b exp=0", res_valid); end
    endtask

    task automatic test_flush_mid();
        res_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            alloc(3'd0, 2'd0, 32'd0, 3'(k), 1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'd1);
            step();
        end
        idle();
        total++; if (count !== 4'd5 || res_valid !== 1'b1)
            begin bad++; $display("FAIL mid_pre got=%0d/%b exp=5/1", count, res_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (count !== 4'd0 || res_valid !== 1'b0 || alloc_ready !== 1'b1 || res_value !== 32'd0)
            begin bad++; $display("FAIL mid_rst got=%0d/%b/%b/%h exp=0/0/1/0",
                count, res_valid, alloc_ready, res_value); end
        for (int k = 0; k < 3; k++) begin
            alloc(3'd0, 2'd0, 32'd0, 3'(k + 1), 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd1);
            step();
        end
        cdb(0, 3'd6, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        total++; if (count !== 4'd0 || res_valid !== 1'b0 || res_tag !== 3'd0)
            begin bad++; $display("FAIL mid_flush got=%0d/%b/%0d exp=0/0/0", count, res_valid, res_tag); end
        step();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_quiet got=%b exp=0", res_valid); end
        res_ready = 1'b1;
    endtask

    task automatic test_jumps();
        alloc(3'd0, 2'd1, 32'h200, 3'd5, 1'b1, 3'd0, 32'h200, 1'b1, 3'd0, 32'd8);
        step(); idle();
        step();
        total++; if (res_value !== 32'h204 || res_target !== 32'h208)
            begin bad++; $display("FAIL jal got=%h/%h exp=204/208", res_value, res_target); end
        step();
        alloc(3'd0, 2'd2, 32'h100, 3'd6, 1'b1, 3'd0, 32'h203, 1'b1, 3'd0, 32'd0);
        step();
        alloc(3'd0, 2'd0, 32'd0, 3'd7, 1'b0, 3'd6, 32'd0, 1'b1, 3'd0, 32'd1);
        step(); idle();
        total++; if (res_valid !== 1'b1 || res_tag !== 3'd6 || res_value !== 32'h104 || res_target !== 32'h202)
            begin bad++; $display("FAIL jalr got=%b/%0d/%h/%h exp=1/6/104/202",
                res_valid, res_tag, res_value, res_target); end
        step();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL jalr_gap got=%b exp=0", res_valid); end
        step();
`ifdef ALU_RS_SELF_WAKE_EN
        total++; if (res_valid !== 1'b1 || res_tag !== 3'd7 || res_value !== 32'h105 || res_target !== 32'd0)
            begin bad++; $display("FAIL selfwake got=%b/%0d/%h exp=1/7/105", res_valid, res_tag, res_value); end
`else
        total++; if (res_valid !== 1'b0 || count !== 4'd1)
            begin bad++; $display("FAIL nowake got=%b/%0d exp=0/1", res_valid, count); end
        cdb(0, 3'd6, 32'h104);
        step(); idle();
        step();
        total++; if (res_valid !== 1'b1 || res_tag !== 3'd7 || res_value !== 32'h105 || res_target !== 32'd0)
            begin bad++; $display("FAIL cdbwake got=%b/%0d/%h exp=1/7/105", res_valid, res_tag, res_value); end
`endif
        step();
        total++; if (count !== 4'd0) begin bad++; $display("FAIL jmp_end got=%0d exp=0", count); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; res_ready = 1'b1;
        alloc_valid = 1'b0; a_op = '0; a_jmp = '0; a_pc = '0; a_rob = '0;
        a_r1rdy = 1'b0; a_r1tag = '0; a_r1val = '0;
        a_r2rdy = 1'b0; a_r2tag = '0; a_r2val = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        test_reset();
        test_add();
        test_bypass();
        test_dup_lanes();
        test_wake_order();
        test_back_to_back();
        test_full();
        test_flush_mid();
        test_jumps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
